scene_renderer: RTL and testbench



---
 rtl/scene_renderer.sv | 128 ++++++++++++
 tb/tb_scene_renderer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scene_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scene_renderer: per-pixel RGB332 colour for walls, paddle and ball.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module scene_renderer #(
  parameter int         GAME_BEGIN_X = 160,
  parameter int         GAME_END_X   = 640,
  parameter int         GAME_TOP_Y   = 40,
  parameter int         WALL_W       = 8,
  parameter int         PADDLE_Y     = 440,
  parameter int         PADDLE_LEN   = 60,
  parameter int         PADDLE_H     = 8,
  parameter int         BALL_SIZE    = 10,
  parameter logic [7:0] BALL_COLOR   = 8'hFF,
  parameter logic [7:0] PADDLE_COLOR = 8'hE0,
  parameter logic [7:0] WALL_COLOR   = 8'h92,
  parameter logic [7:0] BG_COLOR     = 8'h00
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [9:0] PIXEL_X,
  input  logic [9:0] PIXEL_Y,
  input  logic       PIXEL_VALID,
  input  logic       LOAD_POSITIONS,
  input  logic [9:0] PADDLE_X_PIXEL,
  input  logic [9:0] BALL_X_PIXEL,
  input  logic [9:0] BALL_Y_PIXEL,
  output logic [7:0] COLOR,
  output logic       COLOR_VALID
);

  localparam logic [9:0]  c_rst_paddle_x = 10'd370;
  localparam logic [9:0]  c_rst_ball_x   = 10'd395;
  localparam logic [9:0]  c_rst_ball_y   = 10'd400;

  localparam logic [10:0] c_wall_x0   = 11'(GAME_BEGIN_X - WALL_W);
  localparam logic [10:0] c_field_x0  = 11'(GAME_BEGIN_X);
  localparam logic [10:0] c_field_x1  = 11'(GAME_END_X);
  localparam logic [10:0] c_wall_x1   = 11'(GAME_END_X + WALL_W);
  localparam logic [10:0] c_wall_y0   = 11'(GAME_TOP_Y - WALL_W);
  localparam logic [10:0] c_field_y0  = 11'(GAME_TOP_Y);
  localparam logic [10:0] c_paddle_y0 = 11'(PADDLE_Y);
  localparam logic [10:0] c_paddle_y1 = 11'(PADDLE_Y + PADDLE_H);

  logic [9:0]  r_paddle_x;
  logic [9:0]  r_ball_x;
  logic [9:0]  r_ball_y;

  logic        r_s1_valid;
  logic        r_hit_ball;
  logic        r_hit_paddle;
  logic        r_hit_wall;
  logic        r_hit_field;

  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [10:0] w_px;
  logic [10:0] w_bx;
  logic [10:0] w_by;
  logic        w_hit_ball;
  logic        w_hit_paddle;
  logic        w_hit_wall;
  logic        w_hit_field;

  // Frame-stable copies of the game-logic positions; a scan on the load edge still sees the old values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_paddle_x <= c_rst_paddle_x;
      r_ball_x   <= c_rst_ball_x;
      r_ball_y   <= c_rst_ball_y;
    end else if (LOAD_POSITIONS) begin
      r_paddle_x <= PADDLE_X_PIXEL;
      r_ball_x   <= BALL_X_PIXEL;
      r_ball_y   <= BALL_Y_PIXEL;
    end
  end

  // Widened to 11 bits so object right/bottom edges never wrap past column/row 1023.
  assign w_x  = {1'b0, PIXEL_X};
  assign w_y  = {1'b0, PIXEL_Y};
  assign w_px = {1'b0, r_paddle_x};
  assign w_bx = {1'b0, r_ball_x};
  assign w_by = {1'b0, r_ball_y};

  assign w_hit_ball   = (w_x >= w_bx) && (w_x < w_bx + 11'(BALL_SIZE)) &&
                        (w_y >= w_by) && (w_y < w_by + 11'(BALL_SIZE));
  assign w_hit_paddle = (w_x >= w_px) && (w_x < w_px + 11'(PADDLE_LEN)) &&
                        (w_y >= c_paddle_y0) && (w_y < c_paddle_y1);
  assign w_hit_wall   = ((w_x >= c_wall_x0) && (w_x < c_field_x0) && (w_y >= c_wall_y0)) ||
                        ((w_x >= c_field_x1) && (w_x < c_wall_x1) && (w_y >= c_wall_y0)) ||
                        ((w_y >= c_wall_y0) && (w_y < c_field_y0) &&
                         (w_x >= c_wall_x0) && (w_x < c_wall_x1));
  assign w_hit_field  = (w_x >= c_field_x0) && (w_x < c_field_x1) && (w_y >= c_field_y0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1_valid   <= 1'b0;
      r_hit_ball   <= 1'b0;
      r_hit_paddle <= 1'b0;
      r_hit_wall   <= 1'b0;
      r_hit_field  <= 1'b0;
    end else begin
      r_s1_valid   <= PIXEL_VALID;
      r_hit_ball   <= w_hit_ball;
      r_hit_paddle <= w_hit_paddle;
      r_hit_wall   <= w_hit_wall;
      r_hit_field  <= w_hit_field;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      COLOR       <= 8'h00;
      COLOR_VALID <= 1'b0;
    end else begin
      COLOR_VALID <= r_s1_valid;
      if (!r_s1_valid)       COLOR <= 8'h00;
      else if (r_hit_ball)   COLOR <= BALL_COLOR;
      else if (r_hit_paddle) COLOR <= PADDLE_COLOR;
      else if (r_hit_wall)   COLOR <= WALL_COLOR;
      else if (r_hit_field)  COLOR <= BG_COLOR;
      else                   COLOR <= 8'h00;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scene_renderer.sv
`default_nettype none
// Self-checking bench for scene_renderer: directed scenarios plus a randomized stream vs. a rule-based model.
module tb_scene_renderer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic [9:0] PIXEL_X = '0;
  logic [9:0] PIXEL_Y = '0;
  logic       PIXEL_VALID = 1'b0;
  logic       LOAD_POSITIONS = 1'b0;
  logic [9:0] PADDLE_X_PIXEL = '0;
  logic [9:0] BALL_X_PIXEL = '0;
  logic [9:0] BALL_Y_PIXEL = '0;
  logic [7:0] COLOR;
  logic       COLOR_VALID;

  int checks = 0;
  int failures = 0;
  int m_px = 370;
  int m_bx = 395;
  int m_by = 400;

  scene_renderer dut (
    .CLK(CLK), .RST_N(RST_N),
    .PIXEL_X(PIXEL_X), .PIXEL_Y(PIXEL_Y), .PIXEL_VALID(PIXEL_VALID),
    .LOAD_POSITIONS(LOAD_POSITIONS),
    .PADDLE_X_PIXEL(PADDLE_X_PIXEL), .BALL_X_PIXEL(BALL_X_PIXEL), .BALL_Y_PIXEL(BALL_Y_PIXEL),
    .COLOR(COLOR), .COLOR_VALID(COLOR_VALID)
  );

  always #5 CLK = ~CLK;

  // Scene rules written directly as plain integer geometry.
  function automatic logic [7:0] ref_color(int x, int y, bit v, int px, int bx, int by);
    if (!v) return 8'h00;
    if (x >= bx && x < bx + 10 && y >= by && y < by + 10) return 8'hFF;
    if (x >= px && x < px + 60 && y >= 440 && y < 448) return 8'hE0;
    if (x >= 152 && x < 160 && y >= 32) return 8'h92;
    if (x >= 640 && x < 648 && y >= 32) return 8'h92;
    if (y >= 32 && y < 40 && x >= 152 && x < 648) return 8'h92;
    if (x >= 160 && x < 640 && y >= 40) return 8'h00;
    return 8'h00;
  endfunction

  // Drives one pixel (optionally with a load on the same edge) and returns the output two edges later.
  task automatic run_pixel(input int x, input int y, input bit v, input bit ld,
                           input int lpx, input int lbx, input int lby,
                           output logic [7:0] col, output logic cv);
    PIXEL_X = 10'(x); PIXEL_Y = 10'(y); PIXEL_VALID = v;
    LOAD_POSITIONS = ld;
    PADDLE_X_PIXEL = 10'(lpx); BALL_X_PIXEL = 10'(lbx); BALL_Y_PIXEL = 10'(lby);
    @(posedge CLK);
    if (ld) begin m_px = lpx; m_bx = lbx; m_by = lby; end
    #1;
    LOAD_POSITIONS = 1'b0; PIXEL_VALID = 1'b0;
    @(posedge CLK);
    #1;
    col = COLOR; cv = COLOR_VALID;
  endtask

  task automatic test_reset();
    #1 RST_N = 1'b0;
    #1;
    checks++;
    if (COLOR !== 8'h00 || COLOR_VALID !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: color=%h valid=%b, required color=00 valid=0", COLOR, COLOR_VALID);
    end
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    m_px = 370; m_bx = 395; m_by = 400;
    PIXEL_X = 10'd400; PIXEL_Y = 10'd405; PIXEL_VALID = 1'b1;
    @(posedge CLK);
    #1;
    PIXEL_VALID = 1'b0;
    checks++;
    if (COLOR !== 8'h00 || COLOR_VALID !== 1'b0) begin
      failures++;
      $display("FAIL first_pixel_early: color=%h valid=%b, required color=00 valid=0", COLOR, COLOR_VALID);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (COLOR !== 8'hFF || COLOR_VALID !== 1'b1) begin
      failures++;
      $display("FAIL first_pixel_ball: color=%h valid=%b, required color=ff valid=1", COLOR, COLOR_VALID);
    end
  endtask

  task automatic test_paddle();
    int xs[4] = '{199, 200, 259, 260};
    logic [7:0] exp_c[4] = '{8'h00, 8'hE0, 8'hE0, 8'h00};
    logic [7:0] c;
    logic cv;
    run_pixel(380, 444, 1'b1, 1'b1, 200, 395, 400, c, cv);
    checks++;
    if (c !== 8'hE0 || cv !== 1'b1) begin
      failures++;
      $display("FAIL paddle_load_edge_old: color=%h valid=%b, required color=e0 valid=1", c, cv);
    end
    for (int i = 0; i < 4; i++) begin
      run_pixel(xs[i], 444, 1'b1, 1'b0, 0, 0, 0, c, cv);
      checks++;
      if (c !== exp_c[i] || cv !== 1'b1) begin
        failures++;
        $display("FAIL paddle_x%0d: color=%h valid=%b, required color=%h valid=1", xs[i], c, cv, exp_c[i]);
      end
    end
    run_pixel(380, 444, 1'b1, 1'b0, 0, 0, 0, c, cv);
    checks++;
    if (c !== 8'h00 || cv !== 1'b1) begin
      failures++;
      $display("FAIL paddle_old_gone: color=%h valid=%b, required color=00 valid=1", c, cv);
    end
  endtask

  task automatic test_ball_priority();
    logic [7:0] c;
    logic cv;
    run_pixel(0, 0, 1'b0, 1'b1, 200, 205, 436, c, cv);
    run_pixel(207, 441, 1'b1, 1'b0, 0, 0, 0, c, cv);
    checks++;
    if (c !== 8'hFF || cv !== 1'b1) begin
      failures++;
      $display("FAIL ball_over_paddle: color=%h valid=%b, required color=ff valid=1", c, cv);
    end
    run_pixel(215, 446, 1'b1, 1'b0, 0, 0, 0, c, cv);
    checks++;
    if (c !== 8'hE0 || cv !== 1'b1) begin
      failures++;
      $display("FAIL paddle_beside_ball: color=%h valid=%b, required color=e0 valid=1", c, cv);
    end
  endtask

  task automatic test_walls();
    int xs[6] = '{152, 647, 300, 300, 648, 160};
    int ys[6] = '{100, 100, 32, 39, 100, 40};
    logic [7:0] exp_c[6] = '{8'h92, 8'h92, 8'h92, 8'h92, 8'h00, 8'h00};
    logic [7:0] c;
    logic cv;
    for (int i = 0; i < 6; i++) begin
      run_pixel(xs[i], ys[i], 1'b1, 1'b0, 0, 0, 0, c, cv);
      checks++;
      if (c !== exp_c[i] || cv !== 1'b1) begin
        failures++;
        $display("FAIL wall_%0d_%0d: color=%h valid=%b, required color=%h valid=1", xs[i], ys[i], c, cv, exp_c[i]);
      end
    end
  endtask

  task automatic test_no_wrap();
    logic [7:0] c;
    logic cv;
    run_pixel(0, 0, 1'b0, 1'b1, 200, 1020, 100, c, cv);
    for (int x = 1020; x < 1024; x++) begin
      run_pixel(x, 100, 1'b1, 1'b0, 0, 0, 0, c, cv);
      checks++;
      if (c !== 8'hFF || cv !== 1'b1) begin
        failures++;
        $display("FAIL edge_ball_x%0d: color=%h valid=%b, required color=ff valid=1", x, c, cv);
      end
    end
    for (int x = 0; x < 6; x++) begin
      run_pixel(x, 100, 1'b1, 1'b0, 0, 0, 0, c, cv);
      checks++;
      if (c !== 8'h00 || cv !== 1'b1) begin
        failures++;
        $display("FAIL nowrap_x%0d: color=%h valid=%b, required color=00 valid=1", x, c, cv);
      end
    end
    run_pixel(1021, 100, 1'b0, 1'b0, 0, 0, 0, c, cv);
    checks++;
    if (c !== 8'h00 || cv !== 1'b0) begin
      failures++;
      $display("FAIL invalid_on_ball: color=%h valid=%b, required color=00 valid=0", c, cv);
    end
  endtask

  // Continuous one-pixel-per-clock stream with random mid-frame loads.
  task automatic test_back_to_back();
    bit have_prev = 1'b0;
    logic [7:0] prev_c = 8'h00, cur_c;
    bit prev_v = 1'b0, cur_v;
    int x, y, lpx, lbx, lby;
    bit v, ld;
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0: begin x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023)); end
        1: begin x = (m_bx + int'($urandom_range(0, 13)) - 2) & 1023;
                 y = (m_by + int'($urandom_range(0, 13)) - 2) & 1023; end
        2: begin x = (m_px + int'($urandom_range(0, 63)) - 2) & 1023;
                 y = 436 + int'($urandom_range(0, 15)); end
        default: begin x = int'($urandom_range(148, 651)); y = int'($urandom_range(28, 44)); end
      endcase
      v   = ($urandom_range(0, 9) != 0);
      ld  = ($urandom_range(0, 19) == 0);
      lpx = int'($urandom_range(0, 1023));
      lbx = ($urandom_range(0, 1) != 0) ? lpx + int'($urandom_range(0, 60)) - 5 : int'($urandom_range(0, 1023));
      lbx = lbx & 1023;
      lby = ($urandom_range(0, 1) != 0) ? int'($urandom_range(430, 447)) : int'($urandom_range(0, 1023));
      PIXEL_X = 10'(x); PIXEL_Y = 10'(y); PIXEL_VALID = v;
      LOAD_POSITIONS = ld;
      PADDLE_X_PIXEL = 10'(lpx); BALL_X_PIXEL = 10'(lbx); BALL_Y_PIXEL = 10'(lby);
      @(posedge CLK);
      cur_c = ref_color(x, y, v, m_px, m_bx, m_by);
      cur_v = v;
      if (ld) begin m_px = lpx; m_bx = lbx; m_by = lby; end
      #1;
      if (have_prev) begin
        checks++;
        if (COLOR !== prev_c || COLOR_VALID !== prev_v) begin
          failures++;
          $display("FAIL stream_%0d: color=%h valid=%b, required color=%h valid=%b", i, COLOR, COLOR_VALID, prev_c, prev_v);
        end
      end
      prev_c = cur_c; prev_v = cur_v; have_prev = 1'b1;
    end
    LOAD_POSITIONS = 1'b0; PIXEL_VALID = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [7:0] c;
    logic cv;
    run_pixel(0, 0, 1'b0, 1'b1, 100, 600, 200, c, cv);
    PIXEL_X = 10'd605; PIXEL_Y = 10'd205; PIXEL_VALID = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (COLOR !== 8'hFF || COLOR_VALID !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_stream: color=%h valid=%b, required color=ff valid=1", COLOR, COLOR_VALID);
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (COLOR !== 8'h00 || COLOR_VALID !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: color=%h valid=%b, required color=00 valid=0", COLOR, COLOR_VALID);
    end
    PIXEL_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    m_px = 370; m_bx = 395; m_by = 400;
    run_pixel(400, 405, 1'b1, 1'b0, 0, 0, 0, c, cv);
    checks++;
    if (c !== 8'hFF || cv !== 1'b1) begin
      failures++;
      $display("FAIL reset_ball_default: color=%h valid=%b, required color=ff valid=1", c, cv);
    end
    run_pixel(380, 444, 1'b1, 1'b0, 0, 0, 0, c, cv);
    checks++;
    if (c !== 8'hE0 || cv !== 1'b1) begin
      failures++;
      $display("FAIL reset_paddle_default: color=%h valid=%b, required color=e0 valid=1", c, cv);
    end
  endtask

  initial begin
    test_reset();
    test_paddle();
    test_ball_priority();
    test_walls();
    test_no_wrap();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
